// File: rtl/wb_slave_regfile.sv
// Wishbone classic slave modelling the MAC register file and BD RAM,
// with programmable wait states, error termination and an interrupt source register.
module wb_slave_regfile #(
    parameter int          NUM_REGS  = 21,
    parameter int          BD_DEPTH  = 256,
    parameter int          ACK_WAIT  = 0,
    parameter logic [31:0] MODER_RST = 32'h0000A000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [9:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    input  logic [6:0]  irq_set_i,
    output logic        int_o,
    output logic [31:0] moder_o
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_WAIT   = 2'd1;
    localparam logic [1:0]  ST_RESP   = 2'd2;
    localparam int          BD_AW     = (BD_DEPTH > 1) ? $clog2(BD_DEPTH) : 1;
    localparam logic [3:0]  WAIT_LOAD = (ACK_WAIT > 0) ? 4'(ACK_WAIT - 1) : 4'd0;
    localparam logic [10:0] REG_END   = 11'(NUM_REGS);
    localparam logic [10:0] BD_LO     = 11'h100;
    localparam logic [10:0] BD_END    = 11'(256 + BD_DEPTH);

    logic [1:0]  state_reg;
    logic [3:0]  cnt_reg;
    logic [9:0]  adr_reg;
    logic        we_reg;
    logic [3:0]  sel_reg;
    logic [31:0] dat_reg;
    logic        dec_err_reg;
    logic        dec_bd_reg;
    logic        ack_reg;
    logic        err_reg;
    logic [31:0] rdat_reg;
    logic        int_reg;

    logic [31:0] bd_mem [0:BD_DEPTH-1];
    logic [31:0] bd_q_reg;
    logic [31:0] reg_q [0:63];

    logic        req;
    logic        req_in_reg;
    logic        req_in_bd;
    logic        req_err;
    logic        commit;
    logic [31:0] rd_mux;

    assign req = wb_cyc_i & wb_stb_i;

    always_comb begin
        req_in_reg = ({1'b0, wb_adr_i} < REG_END);
        req_in_bd  = ({1'b0, wb_adr_i} >= BD_LO) && ({1'b0, wb_adr_i} < BD_END);
        req_err    = !((req_in_reg && (wb_sel_i == 4'hF)) || req_in_bd);
    end

    // Writes land on the same edge that raises ack; err cycles never write.
    assign commit = (state_reg == ST_RESP) && we_reg && !dec_err_reg;
    assign rd_mux = dec_bd_reg ? bd_q_reg : reg_q[adr_reg[5:0]];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 4'd0;
            adr_reg     <= 10'd0;
            we_reg      <= 1'b0;
            sel_reg     <= 4'd0;
            dat_reg     <= 32'd0;
            dec_err_reg <= 1'b0;
            dec_bd_reg  <= 1'b0;
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            rdat_reg    <= 32'd0;
        end else begin
            ack_reg  <= 1'b0;
            err_reg  <= 1'b0;
            rdat_reg <= 32'd0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        adr_reg     <= wb_adr_i;
                        we_reg      <= wb_we_i;
                        sel_reg     <= wb_sel_i;
                        dat_reg     <= wb_dat_i;
                        dec_err_reg <= req_err;
                        dec_bd_reg  <= req_in_bd;
                        if (ACK_WAIT == 0) begin
                            state_reg <= ST_RESP;
                        end else begin
                            cnt_reg   <= WAIT_LOAD;
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg == 4'd0) begin
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_RESP: begin
                    ack_reg   <= !dec_err_reg;
                    err_reg   <= dec_err_reg;
                    if (!dec_err_reg && !we_reg) begin
                        rdat_reg <= rd_mux;
                    end
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // BD RAM is read with the live address while idle, so the word is ready by the response edge.
    always_ff @(posedge wb_clk_i) begin
        if (commit && dec_bd_reg) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_reg[b]) begin
                    bd_mem[adr_reg[BD_AW-1:0]][8*b +: 8] <= dat_reg[8*b +: 8];
                end
            end
        end
        if (state_reg == ST_IDLE) begin
            bd_q_reg <= bd_mem[wb_adr_i[BD_AW-1:0]];
        end
    end

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_reg
            if (gi >= NUM_REGS) begin : g_absent
                assign reg_q[gi] = 32'd0;
            end else begin : g_present
                logic wr;
                assign wr = commit && !dec_bd_reg && (adr_reg == 10'(gi));
                if (gi == 1) begin : g_int_source
                    logic [6:0] src_reg;
                    // A set pulse in the same cycle as a write-1-to-clear keeps the bit set.
                    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
                        if (!wb_rst_n_i) begin
                            src_reg <= 7'd0;
                        end else begin
                            src_reg <= (src_reg & ~(wr ? dat_reg[6:0] : 7'd0)) | irq_set_i;
                        end
                    end
                    assign reg_q[gi] = {25'd0, src_reg};
                end else if (gi == 2) begin : g_int_mask
                    logic [6:0] mask_reg;
                    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
                        if (!wb_rst_n_i) begin
                            mask_reg <= 7'd0;
                        end else if (wr) begin
                            mask_reg <= dat_reg[6:0];
                        end
                    end
                    assign reg_q[gi] = {25'd0, mask_reg};
                end else begin : g_plain
                    localparam logic [31:0] RST_VAL = (gi == 0) ? MODER_RST : 32'd0;
                    logic [31:0] q_reg;
                    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
                        if (!wb_rst_n_i) begin
                            q_reg <= RST_VAL;
                        end else if (wr) begin
                            q_reg <= dat_reg;
                        end
                    end
                    assign reg_q[gi] = q_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            int_reg <= 1'b0;
        end else begin
            int_reg <= |(reg_q[1][6:0] & reg_q[2][6:0]);
        end
    end

    assign wb_dat_o = rdat_reg;
    assign wb_ack_o = ack_reg;
    assign wb_err_o = err_reg;
    assign int_o    = int_reg;
    assign moder_o  = reg_q[0];

endmodule
